conv_result_sink: RTL and testbench
===================================

CONV_RESULT_SINK -- requirements
Module: conv_result_sink

Interface
REQ-001 Parameters SHALL be: AddressBitWidth, default 17, write-address width; DataBitWidth, default 12, pixel width; NoOfPixels, default 25, output pixels per frame (5x5); ClampMax, default 12'hFFF, saturation ceiling.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 d_in  input  DataBitWidth  pixel from the upstream conv2d d_out.
REQ-006 WriteAddress  input  AddressBitWidth  upstream write address; valid pixel addresses are 1..NoOfPixels.
REQ-007 WriteEnable  input  1  upstream write strobe.
REQ-008 clear  input  1  discards the frame and returns the block to CAPTURE.
REQ-009 start_dump  input  1  begins the readout stream when the frame is FULL.
REQ-010 out_ready  input  1  downstream accepts out_data.
REQ-011 out_data  output  DataBitWidth  streamed pixel.
REQ-012 out_valid  output  1  out_data is valid.
REQ-013 out_last  output  1  marks the final pixel (index NoOfPixels-1).
REQ-014 full  output  1  all NoOfPixels indices have been written.
REQ-015 done  output  1  dump is complete.
REQ-016 addr_err  output  1  sticky flag: an out-of-range address was written.
REQ-017 overrun  output  1  sticky flag: a write arrived outside CAPTURE.

Function
REQ-018 States SHALL be CAPTURE, FULL, DUMP and DONE.
REQ-019 Transitions: CAPTURE->FULL when the accepted count reaches NoOfPixels; FULL->DUMP on start_dump; DUMP->DONE on the handshake of out_last; DONE->CAPTURE on clear.
REQ-020 In CAPTURE, WriteEnable=1 with WriteAddress in 1..NoOfPixels SHALL write min(d_in, ClampMax) to index WriteAddress-1 one cycle later, via a single registered input stage.
REQ-021 Each index SHALL carry a valid bit; the accepted count SHALL increment only on the first write to an index.
REQ-022 A repeat write to an index (including WriteEnable held high for several cycles) SHALL overwrite the data and SHALL NOT change the count.
REQ-023 WriteEnable=1 with WriteAddress=0 or WriteAddress>NoOfPixels SHALL be dropped and SHALL set addr_err.
REQ-024 WriteEnable=1 in FULL, DUMP or DONE SHALL be dropped and SHALL set overrun.
REQ-025 DUMP SHALL stream indices 0..NoOfPixels-1 in order.
REQ-026 out_valid SHALL rise no later than 2 cycles after start_dump.
REQ-027 out_data, out_valid and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 A pixel is transferred when out_valid=1 and out_ready=1; with out_ready held high the block SHALL sustain 1 pixel per cycle.
REQ-029 full SHALL be high in FULL only; done SHALL be high in DONE only.
REQ-030 clear SHALL override every other input in every state: next state CAPTURE, all valid bits, the count, the flags and out_valid cleared; RAM contents are don't-care.
REQ-031 start_dump outside FULL SHALL be ignored.

Reset
REQ-032 Reset assertion SHALL immediately force: state CAPTURE, count 0, all valid bits 0, out_valid 0, out_last 0, out_data 0, full 0, done 0, addr_err 0, overrun 0.
REQ-033 Reset asserted mid-DUMP SHALL abort the stream with no further handshake.
REQ-034 Reset release SHALL be synchronised to clk before it affects the state register.

Structure
REQ-035 The state encodings, the NoOfColumns/NoOfRows constants and the pixel width SHALL live in the shared conv package, which is also used by conv2d.
REQ-036 Storage SHALL be one sub-module, result_ram: NoOfPixels x DataBitWidth, one synchronous write port and one synchronous read port.

Verification
REQ-037 Writes to addresses 1..25 with d_in=address*3 -> full=1 one cycle after the last write; dump with out_ready=1 yields 3,6,...,75 on consecutive cycles, with out_last on the 25th pixel and done=1 after it.
REQ-038 WriteEnable held high for 3 cycles at address 7 with d_in changing 10,11,12 -> count increases by exactly 1; pixel index 6 dumps as 12.
REQ-039 Writes to addresses 0 and 26 -> addr_err=1 and the count is unchanged; a write of d_in=12'hFFF with ClampMax=12'h0FF -> the pixel dumps as 12'h0FF.
REQ-040 During dump, toggle out_ready 1,0,0,1 -> out_data is held through the stall, with no pixel lost or duplicated.
REQ-041 Assert clear during pixel 10 of a dump -> state CAPTURE and out_valid=0 the next cycle; a fresh 25-write frame completes normally.
REQ-042 Assert rst low mid-DUMP -> all outputs are 0 immediately; a write in FULL -> overrun=1 and the stored data is unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared conv package: frame geometry, pixel width and the result-sink state
// encoding. conv2d and conv_result_sink both import it so the frame size and
// pixel width stay consistent across the pipeline.
package conv_pkg;

  localparam int NoOfColumns = 5;
  localparam int NoOfRows    = 5;
  localparam int PixelWidth  = 12;

  // Result sink life cycle: collect a frame, wait for a dump request,
  // stream it out, then park until the frame is cleared.
  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    FULL    = 2'd1,
    DUMP    = 2'd2,
    DONE    = 2'd3
  } sink_state_e;

endpackage : conv_pkg

// File: rtl/conv_result_sink_result_ram.sv
// result_ram: frame storage for conv_result_sink.
// Depth x DataBitWidth array, one synchronous write port and one synchronous
// (registered) read port.
//   clk        rising-edge clock
//   wr_en_i    write strobe
//   wr_addr_i  write index
//   wr_data_i  write data
//   rd_addr_i  read index, sampled every cycle
//   rd_data_o  data at rd_addr_i from the previous cycle
module result_ram #(
  parameter int DataBitWidth = 12,
  parameter int Depth        = 25,
  parameter int AddrW        = $clog2(Depth)
) (
  input  logic                    clk,
  input  logic                    wr_en_i,
  input  logic [AddrW-1:0]        wr_addr_i,
  input  logic [DataBitWidth-1:0] wr_data_i,
  input  logic [AddrW-1:0]        rd_addr_i,
  output logic [DataBitWidth-1:0] rd_data_o
);

  logic [DataBitWidth-1:0] mem_q [Depth];
  logic [DataBitWidth-1:0] rd_data_q;

  // Write-first: the frame can go FULL on the same edge its last pixel is
  // still sitting in the input stage, so a dump that starts right away may
  // read the index being written.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_q <= wr_data_i;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : result_ram

// File: rtl/conv_result_sink.sv
// conv_result_sink: captures one frame of conv2d output pixels, then streams
// it out over a valid/ready interface on request.
//   clk           rising-edge clock
//   rst           asynchronous active-low reset (release synchronised here)
//   d_in          pixel from conv2d
//   WriteAddress  1-based pixel address (valid 1..NoOfPixels)
//   WriteEnable   write strobe
//   clear         discard the frame, back to CAPTURE (overrides everything)
//   start_dump    start streaming once the frame is FULL
//   out_ready     downstream ready
//   out_data      streamed pixel (0 while out_valid is low)
//   out_valid     out_data valid
//   out_last      final pixel of the frame
//   full          frame complete, waiting for start_dump
//   done          frame streamed out
//   addr_err      sticky: write with an out-of-range address
//   overrun       sticky: write arrived outside CAPTURE
module conv_result_sink
  import conv_pkg::*;
#(
  parameter int AddressBitWidth = 17,
  parameter int DataBitWidth    = PixelWidth,
  parameter int NoOfPixels      = NoOfColumns * NoOfRows,
  parameter logic [DataBitWidth-1:0] ClampMax = DataBitWidth'(12'hFFF)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DataBitWidth-1:0]    d_in,
  input  logic [AddressBitWidth-1:0] WriteAddress,
  input  logic                       WriteEnable,
  input  logic                       clear,
  input  logic                       start_dump,
  input  logic                       out_ready,
  output logic [DataBitWidth-1:0]    out_data,
  output logic                       out_valid,
  output logic                       out_last,
  output logic                       full,
  output logic                       done,
  output logic                       addr_err,
  output logic                       overrun
);

  localparam int IdxW = $clog2(NoOfPixels);
  localparam int CntW = $clog2(NoOfPixels + 1);

  // Reset: asserts asynchronously, releases two clock edges later.
  logic [1:0] rst_sync_q;
  logic       rst_n_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_sync = rst_sync_q[1];

  sink_state_e             state_q, state_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [NoOfPixels-1:0]   valid_q, valid_d;
  logic                    addr_err_q, addr_err_d;
  logic                    overrun_q, overrun_d;
  logic                    wr_en_q, wr_en_d;
  logic [IdxW-1:0]         wr_idx_q, wr_idx_d;
  logic [DataBitWidth-1:0] wr_data_q, wr_data_d;
  logic [IdxW-1:0]         rd_idx_q, rd_idx_d;
  logic                    out_valid_q, out_valid_d;

  logic                    addr_in_range;
  logic [IdxW-1:0]         wr_idx_in;
  logic [DataBitWidth-1:0] clamped_in;
  logic                    handshake;
  logic                    at_last;
  logic [DataBitWidth-1:0] ram_rd_data;

  assign addr_in_range = (WriteAddress != '0) &&
                         (WriteAddress <= AddressBitWidth'(NoOfPixels));
  assign wr_idx_in     = IdxW'(WriteAddress - AddressBitWidth'(1));
  assign clamped_in    = (d_in > ClampMax) ? ClampMax : d_in;
  assign handshake     = out_valid_q && out_ready;
  assign at_last       = (rd_idx_q == IdxW'(NoOfPixels - 1));

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    valid_d     = valid_q;
    addr_err_d  = addr_err_q;
    overrun_d   = overrun_q;
    wr_en_d     = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;
    rd_idx_d    = rd_idx_q;
    out_valid_d = out_valid_q;

    if (WriteEnable && !addr_in_range) begin
      addr_err_d = 1'b1;
    end
    if (WriteEnable && (state_q != CAPTURE)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      CAPTURE: begin
        if (WriteEnable && addr_in_range) begin
          wr_en_d   = 1'b1;
          wr_idx_d  = wr_idx_in;
          wr_data_d = clamped_in;
          // Only the first write to an index counts toward a full frame;
          // repeats just overwrite the data.
          if (!valid_q[wr_idx_in]) begin
            valid_d[wr_idx_in] = 1'b1;
            count_d            = count_q + CntW'(1);
          end
          if (count_d == CntW'(NoOfPixels)) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (start_dump) begin
          state_d     = DUMP;
          rd_idx_d    = '0;
          out_valid_d = 1'b1;
        end
      end
      DUMP: begin
        if (handshake) begin
          if (at_last) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
          end else begin
            rd_idx_d = rd_idx_q + IdxW'(1);
          end
        end
      end
      DONE: begin
      end
      default: begin
        state_d = CAPTURE;
      end
    endcase

    if (clear) begin
      state_d     = CAPTURE;
      count_d     = '0;
      valid_d     = '0;
      addr_err_d  = 1'b0;
      overrun_d   = 1'b0;
      wr_en_d     = 1'b0;
      rd_idx_d    = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q     <= CAPTURE;
      count_q     <= '0;
      valid_q     <= '0;
      addr_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      addr_err_q  <= addr_err_d;
      overrun_q   <= overrun_d;
      wr_en_q     <= wr_en_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  // The read address follows the next presented index, so the registered
  // read lines up with rd_idx_q and simply re-reads the same word on a stall.
  result_ram #(
    .DataBitWidth(DataBitWidth),
    .Depth       (NoOfPixels),
    .AddrW       (IdxW)
  ) u_result_ram (
    .clk      (clk),
    .wr_en_i  (wr_en_q),
    .wr_addr_i(wr_idx_q),
    .wr_data_i(wr_data_q),
    .rd_addr_i(rd_idx_d),
    .rd_data_o(ram_rd_data)
  );

  // RAM output is not resettable; gating with out_valid keeps out_data at 0
  // whenever nothing is being presented, including during reset.
  assign out_data  = out_valid_q ? ram_rd_data : '0;
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q && at_last;
  assign full      = (state_q == FULL);
  assign done      = (state_q == DONE);
  assign addr_err  = addr_err_q;
  assign overrun   = overrun_q;

endmodule : conv_result_sink

// File: tb/tb_conv_result_sink.sv
module tb_conv_result_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] d_in = '0;
  logic [16:0] WriteAddress = '0;
  logic        WriteEnable = 1'b0;
  logic        clear = 1'b0;
  logic        start_dump = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        full;
  logic        done;
  logic        addr_err;
  logic        overrun;

  conv_result_sink #(
    .AddressBitWidth(17),
    .DataBitWidth   (12),
    .NoOfPixels     (25),
    .ClampMax       (12'h0FF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .d_in        (d_in),
    .WriteAddress(WriteAddress),
    .WriteEnable (WriteEnable),
    .clear       (clear),
    .start_dump  (start_dump),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .full        (full),
    .done        (done),
    .addr_err    (addr_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model of the frame as the specification defines it.
  logic [11:0] exp_mem [25];
  logic [24:0] mvalid;
  int          mcount;
  logic        mcap;
  logic        maerr;
  logic        movr;
  logic [11:0] exp_q [$];

  typedef struct {
    logic        we;
    logic [16:0] addr;
    logic [11:0] din;
    logic        exp_aerr;
  } vec_t;
  vec_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mvalid = '0;
    mcount = 0;
    mcap   = 1'b1;
    maerr  = 1'b0;
    movr   = 1'b0;
  endtask

  task automatic drive_write(input logic we, input logic [16:0] addr, input logic [11:0] din);
    logic was_cap;
    int   idx;
    was_cap      = mcap;
    idx          = int'(addr) - 1;
    WriteEnable  = we;
    WriteAddress = addr;
    d_in         = din;
    if (we) begin
      if (addr == 0 || addr > 25) begin
        maerr = 1'b1;
      end else if (was_cap) begin
        exp_mem[idx] = (din > 12'h0FF) ? 12'h0FF : din;
        if (!mvalid[idx]) begin
          mvalid[idx] = 1'b1;
          mcount++;
          if (mcount == 25) mcap = 1'b0;
        end
      end
      if (!was_cap) movr = 1'b1;
    end
    tick();
    $display("write we=%0d addr=%0d din=%0d -> full=%0d addr_err=%0d overrun=%0d",
             we, addr, din, full, addr_err, overrun);
    check("write_full", full, !mcap);
    check("write_addr_err", addr_err, maerr);
    check("write_overrun", overrun, movr);
  endtask

  task automatic fill(input int mult);
    for (int a = 1; a <= 25; a++) begin
      if (!mvalid[a-1]) drive_write(1'b1, 17'(a), 12'(a * mult));
    end
    WriteEnable = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    check("clear_full", full, 0);
    check("clear_done", done, 0);
    check("clear_addr_err", addr_err, 0);
    check("clear_overrun", overrun, 0);
  endtask

  // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0,1.
  // abort_kind 1: clear while pixel abort_at is presented; 2: reset instead.
  task automatic run_dump(input int mode, input int abort_at, input int abort_kind);
    int          popped;
    int          cyc;
    int          gaps;
    int          wait_cyc;
    logic        stalled;
    logic [11:0] held_data;
    logic        held_last;
    logic        rdy;
    logic [11:0] expv;
    popped = 0; cyc = 0; gaps = 0; wait_cyc = 0;
    stalled = 1'b0; held_data = '0; held_last = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 25; i++) exp_q.push_back(exp_mem[i]);
    out_ready  = 1'b0;
    start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    while (!out_valid && wait_cyc < 1) begin
      tick();
      wait_cyc++;
    end
    check("dump_valid_rise", out_valid, 1);
    check("dump_full_low", full, 0);
    if (!out_valid) return;
    while (popped < 25 && cyc < 300) begin
      if (abort_kind == 1 && popped == abort_at) begin
        out_ready = 1'b1;
        clear     = 1'b1;
        tick();
        clear     = 1'b0;
        out_ready = 1'b0;
        model_clear();
        $display("clear at pixel %0d -> out_valid=%0d full=%0d done=%0d", abort_at, out_valid, full, done);
        check("abort_clear_valid", out_valid, 0);
        check("abort_clear_full", full, 0);
        check("abort_clear_done", done, 0);
        check("abort_clear_addr_err", addr_err, 0);
        tick();
        check("abort_clear_valid_hold", out_valid, 0);
        return;
      end
      if (abort_kind == 2 && popped == abort_at) begin
        out_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        $display("reset at pixel %0d -> out_valid=%0d out_data=%0d", abort_at, out_valid, out_data);
        check("abort_rst_valid", out_valid, 0);
        check("abort_rst_last", out_last, 0);
        check("abort_rst_data", out_data, 0);
        check("abort_rst_full", full, 0);
        check("abort_rst_done", done, 0);
        check("abort_rst_addr_err", addr_err, 0);
        check("abort_rst_overrun", overrun, 0);
        tick();
        tick();
        check("abort_rst_valid_hold", out_valid, 0);
        out_ready = 1'b0;
        rst = 1'b1;
        tick(); tick(); tick();
        model_clear();
        check("post_rst_valid", out_valid, 0);
        check("post_rst_done", done, 0);
        return;
      end
      rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (!out_valid) begin
        gaps++;
      end else begin
        if (stalled) begin
          check("stall_data_hold", out_data, held_data);
          check("stall_last_hold", out_last, held_last);
        end
        if (rdy) begin
          expv = exp_q.pop_front();
          $display("pixel %0d: out_data=%0d expected=%0d out_last=%0d", popped, out_data, expv, out_last);
          check("pixel_data", out_data, expv);
          check("pixel_last", out_last, (popped == 24));
          popped++;
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          held_data = out_data;
          held_last = out_last;
        end
      end
      out_ready = rdy;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check("dump_pixel_count", popped, 25);
    check("dump_gaps", gaps, 0);
    check("dump_done", done, 1);
    check("dump_valid_after_last", out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1'b1, 17'd7,  12'd10,   1'b0};
    tbl[1] = '{1'b1, 17'd7,  12'd11,   1'b0};
    tbl[2] = '{1'b1, 17'd7,  12'd12,   1'b0};
    tbl[3] = '{1'b1, 17'd1,  12'hFFF,  1'b0};
    tbl[4] = '{1'b1, 17'd2,  12'h100,  1'b0};
    tbl[5] = '{1'b1, 17'd3,  12'h0FF,  1'b0};
    tbl[6] = '{1'b1, 17'd4,  12'h0FE,  1'b0};
    tbl[7] = '{1'b0, 17'd5,  12'd999,  1'b0};
    tbl[8] = '{1'b1, 17'd0,  12'd7,    1'b1};
    tbl[9] = '{1'b1, 17'd26, 12'd7,    1'b1};
    for (int i = 0; i < 25; i++) exp_mem[i] = '0;
    model_clear();

    // Reset state
    rst = 1'b0;
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_full", full, 0);
    check("rst_done", done, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b1;
    tick(); tick(); tick();

    // start_dump outside FULL is ignored
    start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    tick();
    check("ignored_start_valid", out_valid, 0);
    check("ignored_start_full", full, 0);

    // Frame A: address*3, full-rate dump
    fill(3);
    run_dump(0, -1, 0);
    do_clear();

    // Frame B: table of corner writes, then fill, dump with stalls
    for (int i = 0; i < 10; i++) begin
      drive_write(tbl[i].we, tbl[i].addr, tbl[i].din);
      check("table_addr_err", addr_err, tbl[i].exp_aerr);
    end
    WriteEnable = 1'b0;
    fill(3);
    run_dump(1, -1, 0);
    do_clear();

    // Frame C aborted by clear at pixel 10, then a fresh frame D
    fill(5);
    run_dump(0, 10, 1);
    fill(7);
    run_dump(0, -1, 0);
    do_clear();

    // Frame E: write while FULL, then reset mid-dump
    fill(9);
    drive_write(1'b1, 17'd3, 12'd999);
    WriteEnable = 1'b0;
    run_dump(0, 5, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_conv_result_sink
